wb_clr_led_fader: RTL

//  Parametrised Wishbone-slave PWM controller for NLED tri-colour (RGB) LEDs.

---
 rtl/wb_clr_led_fader_pkg.sv | 32 +++
 rtl/clr_led_chan.sv | 56 +++++
 rtl/wb_clr_led_fader.sv | 92 +++++++++
 3 files changed

// File: rtl/wb_clr_led_fader_pkg.sv
// wb_clr_led_fader_pkg: register offsets, field positions and address decode for the LED fader
package wb_clr_led_fader_pkg;
  localparam int ADDR_CTRL = 0;
  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_FADING_LSB = 8;
  localparam int CTRL_DONE_LSB = 16;
  localparam int TGT_R_LSB = 20;
  localparam int TGT_G_LSB = 10;
  localparam int TGT_B_LSB = 0;
  localparam int RATE_FADING_BIT = 31;
  typedef enum logic [1:0] {REG_NONE, REG_CTRL, REG_TGT, REG_RATE} reg_kind_e;
  typedef struct packed {
    reg_kind_e  kind;
    logic [2:0] idx;
  } reg_sel_t;
  function automatic int tgt_addr(input int k);
    return 1 + 2 * k;
  endfunction
  function automatic int rate_addr(input int k);
    return 2 + 2 * k;
  endfunction
  // TARGET k sits at 1+2k and RATE k at 2+2k, so (addr-1) splits into {led index, is_rate}
  function automatic reg_sel_t decode_addr(input logic [4:0] addr, input int nled);
    reg_sel_t s;
    logic [4:0] a;
    a = addr - 5'd1;
    s.idx = a[3:1];
    s.kind = addr == 5'(ADDR_CTRL) ? REG_CTRL :
             int'(a[4:1]) < nled ? (a[0] ? REG_RATE : REG_TGT) : REG_NONE;
    return s;
  endfunction
endpackage

// File: rtl/clr_led_chan.sv
// clr_led_chan: one RGB LED - target/current/shadow duties, linear fade stepping, PWM compare
// Ports: clk, rst_n (async, active-low); enable, ctr, wrap from the shared PWM counter;
//  tgt_we/tgt_in and rate_we/rate_in bus writes; led {R,G,B} registered outputs;
//  tgt, rate readback; fading (cur!=tgt); done_set (fade completes on the coming edge).
module clr_led_chan #(
  parameter int PWMBITS  = 9,
  parameter int RATEBITS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [PWMBITS-1:0]      ctr,
  input  logic                    wrap,
  input  logic                    tgt_we,
  input  logic [2:0][PWMBITS-1:0] tgt_in,
  input  logic                    rate_we,
  input  logic [RATEBITS-1:0]     rate_in,
  output logic [2:0]              led,
  output logic [2:0][PWMBITS-1:0] tgt,
  output logic [RATEBITS-1:0]     rate,
  output logic                    fading,
  output logic                    done_set
);
  logic [2:0][PWMBITS-1:0] cur, cur_nx, tgt_nx, shadow;
  logic [RATEBITS-1:0] step_cnt;
  logic step;
  always_comb begin
    step = step_cnt <= RATEBITS'(1);
    tgt_nx = tgt_we ? tgt_in : tgt;
    cur_nx = cur;
    for (int c = 0; c < 3; c++)
      cur_nx[c] = rate == '0 ? tgt[c] :
                  !step || cur[c] == tgt[c] ? cur[c] :
                  cur[c] < tgt[c] ? cur[c] + 1'b1 : cur[c] - 1'b1;
    fading = cur != tgt;
    done_set = fading && cur_nx == tgt_nx;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tgt <= '0;
      cur <= '0;
      shadow <= '0;
      rate <= '0;
      step_cnt <= '0;
      led <= '0;
    end else begin
      tgt <= tgt_nx;
      cur <= cur_nx;
      if (wrap) shadow <= cur;
      if (rate_we) rate <= rate_in;
      // a rate write restarts the step period; otherwise count down and reload on the step
      step_cnt <= rate_we ? rate_in : step ? rate : step_cnt - 1'b1;
      for (int c = 0; c < 3; c++)
        led[c] <= enable && (&shadow[c] || ctr < shadow[c]);
    end
endmodule

// File: rtl/wb_clr_led_fader.sv
// wb_clr_led_fader: Wishbone-slave PWM controller with per-LED RGB linear fading and done interrupt
// Ports: i_clk, i_reset_n (async, active-low); Wishbone i_wb_cyc/stb/we/addr/data in,
//  o_wb_ack (one cycle after stb), o_wb_stall (0), o_wb_data (registered, valid with ack);
//  o_clr_led[3k+2:3k] = {R,G,B} of LED k; o_int = |done, registered.
module wb_clr_led_fader
  import wb_clr_led_fader_pkg::*;
#(
  parameter int NLED     = 4,
  parameter int PWMBITS  = 9,
  parameter int RATEBITS = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [4:0]        i_wb_addr,
  input  logic [31:0]       i_wb_data,
  output logic              o_wb_ack,
  output logic              o_wb_stall,
  output logic [31:0]       o_wb_data,
  output logic [3*NLED-1:0] o_clr_led,
  output logic              o_int
);
  logic [PWMBITS-1:0] ctr;
  logic enable, stb, wr, ctrl_wr;
  reg_sel_t sel;
  logic [NLED-1:0] fading, done_set, done;
  logic [NLED-1:0][2:0] leds;
  logic [NLED-1:0][31:0] ch_rd;
  logic [2:0][PWMBITS-1:0] wr_tgt;
  logic [31:0] rdata;
  logic unused_data;
  assign stb = i_wb_cyc & i_wb_stb;
  assign wr = stb & i_wb_we;
  assign sel = decode_addr(i_wb_addr, NLED);
  assign ctrl_wr = wr && sel.kind == REG_CTRL;
  assign wr_tgt = {i_wb_data[TGT_R_LSB +: PWMBITS], i_wb_data[TGT_G_LSB +: PWMBITS],
                   i_wb_data[TGT_B_LSB +: PWMBITS]};
  assign o_wb_stall = 1'b0;
  assign o_clr_led = leds;
  assign unused_data = ^i_wb_data;
  for (genvar k = 0; k < NLED; k++) begin : g_led
    logic [2:0][PWMBITS-1:0] tgt;
    logic [RATEBITS-1:0] rate;
    clr_led_chan #(.PWMBITS(PWMBITS), .RATEBITS(RATEBITS)) u_chan (
      .clk      (i_clk),
      .rst_n    (i_reset_n),
      .enable   (enable),
      .ctr      (ctr),
      .wrap     (&ctr),
      .tgt_we   (wr && sel.kind == REG_TGT && sel.idx == 3'(k)),
      .tgt_in   (wr_tgt),
      .rate_we  (wr && sel.kind == REG_RATE && sel.idx == 3'(k)),
      .rate_in  (i_wb_data[RATEBITS-1:0]),
      .led      (leds[k]),
      .tgt      (tgt),
      .rate     (rate),
      .fading   (fading[k]),
      .done_set (done_set[k])
    );
    assign ch_rd[k] = sel.kind == REG_RATE ? {fading[k], {(31-RATEBITS){1'b0}}, rate} :
                      {2'b00, 10'(tgt[2]), 10'(tgt[1]), 10'(tgt[0])};
  end
  always_comb begin
    rdata = '0;
    if (sel.kind == REG_CTRL) begin
      rdata[CTRL_EN_BIT] = enable;
      rdata[CTRL_FADING_LSB +: NLED] = fading;
      rdata[CTRL_DONE_LSB +: NLED] = done;
    end
    for (int k = 0; k < NLED; k++)
      if ((sel.kind == REG_TGT || sel.kind == REG_RATE) && sel.idx == 3'(k)) rdata = ch_rd[k];
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      ctr <= '0;
      enable <= 1'b1;
      done <= '0;
      o_int <= 1'b0;
      o_wb_ack <= 1'b0;
      o_wb_data <= '0;
    end else begin
      ctr <= ctr + 1'b1;
      if (ctrl_wr) enable <= i_wb_data[CTRL_EN_BIT];
      // clear-then-set so a completing fade wins over a simultaneous W1C
      done <= (done & ~(ctrl_wr ? i_wb_data[CTRL_DONE_LSB +: NLED] : '0)) | done_set;
      o_int <= |done;
      o_wb_ack <= stb;
      o_wb_data <= stb ? rdata : '0;
    end
endmodule
